// File: rtl/fpu_microcode_invoke_responder_if.sv
// Handshake bundle between the FPU execution units, the invoke responder
// and the microcode sequencer core. The slave view belongs to the responder.
interface fpu_microcode_invoke_responder_if;
   logic        microcode_invoke;
   logic [11:0] microcode_addr;
   logic [79:0] microcode_operand_a;
   logic        microcode_done;
   logic [79:0] microcode_result;
   logic [1:0]  microcode_quadrant;
   logic        microcode_error;
   logic        seq_start;
   logic [11:0] seq_entry;
   logic [79:0] seq_operand;
   logic        seq_abort;
   logic        seq_complete;
   logic [79:0] seq_result;
   logic [1:0]  seq_quadrant;
   logic        seq_fault;
   logic        busy;
   logic        overrun;
   logic        overrun_clr;

   modport slave (
      input  microcode_invoke, microcode_addr, microcode_operand_a,
      output microcode_done, microcode_result, microcode_quadrant, microcode_error,
      output seq_start, seq_entry, seq_operand, seq_abort,
      input  seq_complete, seq_result, seq_quadrant, seq_fault,
      output busy, overrun,
      input  overrun_clr
   );

   modport master (
      output microcode_invoke, microcode_addr, microcode_operand_a,
      input  microcode_done, microcode_result, microcode_quadrant, microcode_error,
      input  seq_start, seq_entry, seq_operand, seq_abort,
      output seq_complete, seq_result, seq_quadrant, seq_fault,
      input  busy, overrun,
      output overrun_clr
   );
endinterface

// File: rtl/fpu_microcode_invoke_responder.sv
// Responder end of the FPU microcode-invoke handshake: accepts an invoke
// (with one pending slot for a request arriving while busy), validates the
// entry address, launches and supervises the microcode sequencer with a
// timeout, and returns result/quadrant/error with a one-cycle done pulse.
module fpu_microcode_invoke_responder #(
   parameter logic [11:0] ENTRY_LO       = 12'h100,
   parameter logic [11:0] ENTRY_HI       = 12'h1FF,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input logic                            clk,
   input logic                            reset,
   fpu_microcode_invoke_responder_if.slave bus
);

   localparam int              CW         = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0]   CNT_TERM   = CW'(TIMEOUT_CYCLES);
   localparam logic [CW-1:0]   CNT_LAST   = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [79:0]     INDEFINITE = 80'hFFFF_C000000000000000;

   typedef enum logic [1:0] {IDLE, START, WAIT, RESPOND} state_t;

   state_t        state;
   logic [CW-1:0] cnt;

   logic          pend_valid;
   logic [11:0]   pend_addr;
   logic [79:0]   pend_operand;

   logic          consume;
   logic          to_slot;
   logic          drop;
   logic          slot_write;
   logic          pend_valid_d;
   logic          req_valid;
   logic          req_legal;
   logic [11:0]   req_addr;
   logic [79:0]   req_operand;

   // Request selection and pending-slot bookkeeping: the slot is consumed in
   // IDLE, and a fresh invoke may refill it on that same edge.
   always_comb begin
      consume      = (state == IDLE) && pend_valid;
      to_slot      = bus.microcode_invoke && ((state != IDLE) || pend_valid);
      drop         = to_slot && pend_valid && !consume;
      slot_write   = to_slot && !drop;
      pend_valid_d = slot_write || (pend_valid && !consume);
      req_valid    = pend_valid || bus.microcode_invoke;
      req_addr     = pend_valid ? pend_addr : bus.microcode_addr;
      req_operand  = pend_valid ? pend_operand : bus.microcode_operand_a;
      req_legal    = (req_addr >= ENTRY_LO) && (req_addr <= ENTRY_HI);
   end

   // Pending slot storage and the sticky overrun flag (clear beats set).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_valid   <= 1'b0;
         pend_addr    <= '0;
         pend_operand <= '0;
         bus.overrun  <= 1'b0;
      end else begin
         pend_valid <= pend_valid_d;
         if (slot_write) begin
            pend_addr    <= bus.microcode_addr;
            pend_operand <= bus.microcode_operand_a;
         end
         if (bus.overrun_clr) begin
            bus.overrun <= 1'b0;
         end else if (drop) begin
            bus.overrun <= 1'b1;
         end
      end
   end

   // Main FSM with registered outputs. Timeout: abort is pulsed in the WAIT
   // cycle where the counter sits at the terminal count; completion in the
   // cycle before wins and suppresses it. The following cycle responds.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state                  <= IDLE;
         cnt                    <= '0;
         bus.microcode_done     <= 1'b0;
         bus.microcode_result   <= '0;
         bus.microcode_quadrant <= '0;
         bus.microcode_error    <= 1'b0;
         bus.seq_start          <= 1'b0;
         bus.seq_entry          <= '0;
         bus.seq_operand        <= '0;
         bus.seq_abort          <= 1'b0;
         bus.busy               <= 1'b0;
      end else begin
         bus.microcode_done <= 1'b0;
         bus.seq_start      <= 1'b0;
         bus.seq_abort      <= 1'b0;
         bus.busy           <= 1'b1;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  if (req_legal) begin
                     bus.seq_entry   <= req_addr;
                     bus.seq_operand <= req_operand;
                     bus.seq_start   <= 1'b1;
                     state           <= START;
                  end else begin
                     bus.microcode_done     <= 1'b1;
                     bus.microcode_error    <= 1'b1;
                     bus.microcode_result   <= INDEFINITE;
                     bus.microcode_quadrant <= 2'd0;
                     state                  <= RESPOND;
                  end
               end else begin
                  bus.busy <= pend_valid_d;
               end
            end
            START: begin
               cnt   <= '0;
               state <= WAIT;
            end
            WAIT: begin
               if (cnt == CNT_TERM) begin
                  bus.microcode_done     <= 1'b1;
                  bus.microcode_error    <= 1'b1;
                  bus.microcode_result   <= INDEFINITE;
                  bus.microcode_quadrant <= 2'd0;
                  state                  <= RESPOND;
               end else if (bus.seq_complete) begin
                  bus.microcode_done     <= 1'b1;
                  bus.microcode_error    <= bus.seq_fault;
                  bus.microcode_result   <= bus.seq_result;
                  bus.microcode_quadrant <= bus.seq_quadrant;
                  state                  <= RESPOND;
               end else begin
                  cnt <= cnt + CW'(1);
                  if (cnt == CNT_LAST) begin
                     bus.seq_abort <= 1'b1;
                  end
               end
            end
            RESPOND: begin
               bus.busy <= pend_valid_d;
               state    <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_microcode_invoke_responder.sv
// Self-checking bench for the microcode-invoke responder. A default instance
// (1024-cycle timeout) and a 16-cycle-timeout instance share the same inputs.
module tb_fpu_microcode_invoke_responder;

   localparam logic [79:0] INDEF = 80'hFFFF_C000000000000000;

   typedef struct {
      logic [11:0] addr;
      logic [79:0] op;
   } req_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;

   fpu_microcode_invoke_responder_if bus ();
   fpu_microcode_invoke_responder_if bus16 ();

   assign bus16.microcode_invoke    = bus.microcode_invoke;
   assign bus16.microcode_addr      = bus.microcode_addr;
   assign bus16.microcode_operand_a = bus.microcode_operand_a;
   assign bus16.seq_complete        = bus.seq_complete;
   assign bus16.seq_result          = bus.seq_result;
   assign bus16.seq_quadrant        = bus.seq_quadrant;
   assign bus16.seq_fault           = bus.seq_fault;
   assign bus16.overrun_clr         = bus.overrun_clr;

   fpu_microcode_invoke_responder dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   fpu_microcode_invoke_responder #(.TIMEOUT_CYCLES(16)) dut16 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus16)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Watchdog so the run can never hang.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference model: expected {error, quadrant, result} from the rules of
   // the handshake, given what the sequencer would return.
   function automatic logic [82:0] expect_done(input logic [11:0] addr, input logic [79:0] sres,
                                               input logic [1:0] squad, input logic sfault,
                                               input logic timed_out);
      if (addr < 12'h100 || addr > 12'h1FF || timed_out) return {1'b1, 2'b00, INDEF};
      return {sfault, squad, sres};
   endfunction

   function automatic logic [79:0] rnd80();
      logic [95:0] t;
      t = {$urandom, $urandom, $urandom};
      return t[79:0];
   endfunction

   function automatic logic [11:0] rnd_legal();
      return 12'h100 + 12'($urandom_range(0, 255));
   endfunction

   function automatic logic [11:0] rnd_illegal();
      if ($urandom_range(0, 1) == 0) return 12'($urandom_range(0, 255));
      return 12'($urandom_range(512, 4095));
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.microcode_invoke    = 1'b0;
      bus.microcode_addr      = '0;
      bus.microcode_operand_a = '0;
      bus.seq_complete        = 1'b0;
      bus.seq_result          = '0;
      bus.seq_quadrant        = '0;
      bus.seq_fault           = 1'b0;
      bus.overrun_clr         = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      step();
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      step();
      vectors++;
      if ({bus.microcode_done, bus.microcode_result, bus.microcode_quadrant, bus.microcode_error,
           bus.seq_start, bus.seq_entry, bus.seq_operand, bus.seq_abort, bus.busy, bus.overrun} !== '0) begin
         miscompares++;
         $display("[TB] FAIL reset_outputs: got done=%b res=%h err=%b start=%b busy=%b ovr=%b expected all 0",
                  bus.microcode_done, bus.microcode_result, bus.microcode_error, bus.seq_start, bus.busy, bus.overrun);
      end
      vectors++;
      if ({bus16.microcode_done, bus16.seq_start, bus16.seq_abort, bus16.busy, bus16.overrun} !== 5'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_outputs16: got %b expected 00000",
                  {bus16.microcode_done, bus16.seq_start, bus16.seq_abort, bus16.busy, bus16.overrun});
      end
      reset = 1'b0;
      step();
   endtask

   task automatic test_valid();
      for (int n = 0; n < 4; n++) begin
         logic [11:0] addr;
         logic [79:0] op, res;
         logic [1:0]  quad;
         logic [82:0] exp;
         int          lat;
         logic        early;
         if (n == 0) begin
            addr = 12'h120; op = 80'h4009_C90FDAA22168C235;
            res = 80'h3FFE_8000000000000000; quad = 2'd2; lat = 50;
         end else begin
            addr = rnd_legal(); op = rnd80(); res = rnd80();
            quad = 2'($urandom_range(0, 3)); lat = $urandom_range(1, 60);
         end
         exp = expect_done(addr, res, quad, 1'b0, 1'b0);
         bus.microcode_invoke = 1'b1; bus.microcode_addr = addr; bus.microcode_operand_a = op;
         step();
         bus.microcode_invoke = 1'b0; bus.microcode_addr = rnd_legal(); bus.microcode_operand_a = rnd80();
         vectors++;
         if ({bus.seq_start, bus.seq_entry, bus.seq_operand} !== {1'b1, addr, op}) begin
            miscompares++;
            $display("[TB] FAIL start_pulse: got start=%b entry=%h op=%h expected start=1 entry=%h op=%h",
                     bus.seq_start, bus.seq_entry, bus.seq_operand, addr, op);
         end
         step();
         vectors++;
         if (bus.seq_start !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL start_width: got %b expected 0", bus.seq_start);
         end
         early = 1'b0;
         for (int i = 1; i < lat; i++) begin
            if (bus.microcode_done || bus.seq_start || bus.seq_abort) early = 1'b1;
            step();
         end
         vectors++;
         if ({early, bus.microcode_done, bus.seq_entry} !== {1'b0, 1'b0, addr}) begin
            miscompares++;
            $display("[TB] FAIL wait_quiet: got early=%b done=%b entry=%h expected 0 0 %h",
                     early, bus.microcode_done, bus.seq_entry, addr);
         end
         bus.seq_complete = 1'b1; bus.seq_result = res; bus.seq_quadrant = quad; bus.seq_fault = 1'b0;
         step();
         bus.seq_complete = 1'b0; bus.seq_result = rnd80(); bus.seq_quadrant = 2'($urandom_range(0, 3));
         vectors++;
         if ({bus.microcode_done, bus.microcode_error, bus.microcode_quadrant, bus.microcode_result} !== {1'b1, exp}) begin
            miscompares++;
            $display("[TB] FAIL done_values: got done=%b %h expected done=1 %h",
                     bus.microcode_done, {bus.microcode_error, bus.microcode_quadrant, bus.microcode_result}, exp);
         end
         step();
         vectors++;
         if ({bus.microcode_done, bus.busy, bus.microcode_error, bus.microcode_quadrant, bus.microcode_result} !== {2'b00, exp}) begin
            miscompares++;
            $display("[TB] FAIL done_hold: got done=%b busy=%b %h expected 0 0 %h", bus.microcode_done, bus.busy,
                     {bus.microcode_error, bus.microcode_quadrant, bus.microcode_result}, exp);
         end
         idle_inputs();
      end
   endtask

   task automatic test_invalid();
      for (int n = 0; n < 4; n++) begin
         logic [11:0] addr;
         logic [82:0] exp;
         addr = (n == 0) ? 12'h050 : rnd_illegal();
         exp = expect_done(addr, rnd80(), 2'd1, 1'b0, 1'b0);
         bus.microcode_invoke = 1'b1; bus.microcode_addr = addr; bus.microcode_operand_a = rnd80();
         step();
         bus.microcode_invoke = 1'b0;
         vectors++;
         if ({bus.microcode_done, bus.seq_start, bus.microcode_error, bus.microcode_quadrant, bus.microcode_result}
             !== {2'b10, exp}) begin
            miscompares++;
            $display("[TB] FAIL invalid_done: addr=%h got done=%b start=%b %h expected 1 0 %h", addr,
                     bus.microcode_done, bus.seq_start,
                     {bus.microcode_error, bus.microcode_quadrant, bus.microcode_result}, exp);
         end
         step();
         vectors++;
         if ({bus.microcode_done, bus.seq_start, bus.busy} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL invalid_after: got %b expected 000", {bus.microcode_done, bus.seq_start, bus.busy});
         end
      end
   endtask

   task automatic test_timeout();
      logic [11:0] addr;
      logic        early;
      do_reset();
      addr = rnd_legal();
      bus.microcode_invoke = 1'b1; bus.microcode_addr = addr; bus.microcode_operand_a = rnd80();
      step();
      bus.microcode_invoke = 1'b0;
      vectors++;
      if (bus16.seq_start !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL timeout_start: got %b expected 1", bus16.seq_start);
      end
      step();
      early = 1'b0;
      for (int i = 1; i < 16; i++) begin
         if (bus16.seq_abort || bus16.microcode_done) early = 1'b1;
         step();
      end
      if (bus16.seq_abort || bus16.microcode_done) early = 1'b1;
      step();
      vectors++;
      if ({early, bus16.seq_abort, bus16.microcode_done} !== 3'b010) begin
         miscompares++;
         $display("[TB] FAIL abort_time: got early=%b abort=%b done=%b expected 0 1 0",
                  early, bus16.seq_abort, bus16.microcode_done);
      end
      step();
      vectors++;
      if ({bus16.seq_abort, bus16.microcode_done, bus16.microcode_error, bus16.microcode_quadrant, bus16.microcode_result}
          !== {2'b01, expect_done(addr, 80'd0, 2'd0, 1'b0, 1'b1)}) begin
         miscompares++;
         $display("[TB] FAIL timeout_done: got abort=%b done=%b err=%b res=%h expected 0 1 1 %h",
                  bus16.seq_abort, bus16.microcode_done, bus16.microcode_error, bus16.microcode_result, INDEF);
      end
      step();
      vectors++;
      if ({bus16.busy, bus16.microcode_done} !== 2'b00) begin
         miscompares++;
         $display("[TB] FAIL timeout_busy: got busy=%b done=%b expected 0 0", bus16.busy, bus16.microcode_done);
      end
   endtask

   task automatic test_race();
      for (int f = 0; f < 2; f++) begin
         logic [11:0] addr;
         logic [79:0] res;
         logic [1:0]  quad;
         logic        early;
         do_reset();
         addr = rnd_legal(); res = rnd80(); quad = 2'($urandom_range(0, 3));
         bus.microcode_invoke = 1'b1; bus.microcode_addr = addr; bus.microcode_operand_a = rnd80();
         step();
         bus.microcode_invoke = 1'b0;
         step();
         early = 1'b0;
         for (int i = 1; i < 16; i++) begin
            if (bus16.seq_abort || bus16.microcode_done) early = 1'b1;
            step();
         end
         bus.seq_complete = 1'b1; bus.seq_result = res; bus.seq_quadrant = quad; bus.seq_fault = f[0];
         step();
         bus.seq_complete = 1'b0; bus.seq_fault = 1'b0;
         vectors++;
         if ({early, bus16.seq_abort, bus16.microcode_done, bus16.microcode_error, bus16.microcode_quadrant,
              bus16.microcode_result} !== {3'b001, expect_done(addr, res, quad, f[0], 1'b0)}) begin
            miscompares++;
            $display("[TB] FAIL race_done: fault=%0d got early=%b abort=%b done=%b err=%b q=%0d res=%h expected 0 0 1 %b %0d %h",
                     f, early, bus16.seq_abort, bus16.microcode_done, bus16.microcode_error,
                     bus16.microcode_quadrant, bus16.microcode_result, f[0], quad, res);
         end
         step();
         vectors++;
         if ({bus16.seq_abort, bus16.microcode_done, bus16.busy} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL race_after: got %b expected 000", {bus16.seq_abort, bus16.microcode_done, bus16.busy});
         end
      end
   endtask

   task automatic test_queue();
      req_t        reqs[3];
      req_t        acc[$];
      int          occ, started, served, cd, last_done;
      logic        drop_expected, stray;
      logic [79:0] seen_op;
      logic [11:0] seen_entry;
      do_reset();
      occ = 0; drop_expected = 1'b0;
      for (int k = 0; k < 3; k++) begin
         reqs[k].addr = rnd_legal();
         reqs[k].op   = rnd80();
         if (occ < 2) begin
            acc.push_back(reqs[k]);
            occ++;
         end else begin
            drop_expected = 1'b1;
         end
      end
      started = 0; served = 0; cd = 0; last_done = -10; seen_op = '0; seen_entry = '0;
      for (int cyc = 0; cyc < 400 && served < acc.size(); cyc++) begin
         if (bus.seq_start === 1'b1) begin
            vectors++;
            if (started >= acc.size() || {bus.seq_entry, bus.seq_operand} !== {acc[started].addr, acc[started].op}) begin
               miscompares++;
               $display("[TB] FAIL queue_start: index %0d got entry=%h op=%h", started, bus.seq_entry, bus.seq_operand);
            end
            if (started == 1) begin
               vectors++;
               if (cyc != last_done + 2) begin
                  miscompares++;
                  $display("[TB] FAIL back_to_back: got start cycle %0d expected %0d", cyc, last_done + 2);
               end
            end
            started++;
            cd = 20;
            seen_op = bus.seq_operand;
            seen_entry = bus.seq_entry;
         end
         if (bus.microcode_done === 1'b1) begin
            vectors++;
            if ({bus.microcode_error, bus.microcode_quadrant, bus.microcode_result}
                !== expect_done(acc[served].addr, ~acc[served].op, acc[served].addr[1:0], 1'b0, 1'b0)) begin
               miscompares++;
               $display("[TB] FAIL queue_done: index %0d got err=%b q=%0d res=%h expected 0 %0d %h", served,
                        bus.microcode_error, bus.microcode_quadrant, bus.microcode_result,
                        acc[served].addr[1:0], ~acc[served].op);
            end
            served++;
            last_done = cyc;
         end
         bus.microcode_invoke = (cyc < 3);
         if (cyc < 3) begin
            bus.microcode_addr = reqs[cyc].addr;
            bus.microcode_operand_a = reqs[cyc].op;
         end
         bus.seq_complete = 1'b0;
         if (cd > 0) begin
            cd--;
            if (cd == 0) begin
               bus.seq_complete = 1'b1;
               bus.seq_result   = ~seen_op;
               bus.seq_quadrant = seen_entry[1:0];
               bus.seq_fault    = 1'b0;
            end
         end
         step();
      end
      idle_inputs();
      vectors++;
      if (served != acc.size()) begin
         miscompares++;
         $display("[TB] FAIL queue_served: got %0d expected %0d", served, acc.size());
      end
      stray = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (bus.seq_start) stray = 1'b1;
         step();
      end
      vectors++;
      if ({stray, bus.busy, bus.overrun} !== {2'b00, drop_expected}) begin
         miscompares++;
         $display("[TB] FAIL queue_drop: got stray=%b busy=%b overrun=%b expected 0 0 %b",
                  stray, bus.busy, bus.overrun, drop_expected);
      end
      bus.overrun_clr = 1'b1;
      step();
      bus.overrun_clr = 1'b0;
      vectors++;
      if (bus.overrun !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL overrun_clr: got %b expected 0", bus.overrun);
      end
   endtask

   task automatic test_reset_mid_wait();
      logic [11:0] addr;
      logic [79:0] op, res;
      logic [1:0]  quad;
      logic        stray;
      do_reset();
      bus.microcode_invoke = 1'b1; bus.microcode_addr = rnd_legal(); bus.microcode_operand_a = rnd80();
      step();
      bus.microcode_addr = rnd_legal(); bus.microcode_operand_a = rnd80();
      step();
      bus.microcode_invoke = 1'b0;
      step();
      step();
      reset = 1'b1;
      #1;
      vectors++;
      if ({bus.microcode_done, bus.microcode_result, bus.microcode_quadrant, bus.microcode_error,
           bus.seq_start, bus.seq_entry, bus.seq_operand, bus.seq_abort, bus.busy, bus.overrun} !== '0) begin
         miscompares++;
         $display("[TB] FAIL async_reset: got entry=%h op=%h busy=%b expected all 0",
                  bus.seq_entry, bus.seq_operand, bus.busy);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      stray = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (bus.seq_start || bus.busy) stray = 1'b1;
      end
      vectors++;
      if (stray !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL pending_lost: got activity=%b expected 0", stray);
      end
      addr = rnd_legal(); op = rnd80(); res = rnd80(); quad = 2'($urandom_range(0, 3));
      bus.microcode_invoke = 1'b1; bus.microcode_addr = addr; bus.microcode_operand_a = op;
      step();
      bus.microcode_invoke = 1'b0;
      vectors++;
      if ({bus.seq_start, bus.seq_entry, bus.seq_operand} !== {1'b1, addr, op}) begin
         miscompares++;
         $display("[TB] FAIL post_reset_start: got start=%b entry=%h expected 1 %h", bus.seq_start, bus.seq_entry, addr);
      end
      step();
      bus.seq_complete = 1'b1; bus.seq_result = res; bus.seq_quadrant = quad; bus.seq_fault = 1'b0;
      step();
      bus.seq_complete = 1'b0;
      vectors++;
      if ({bus.microcode_done, bus.microcode_error, bus.microcode_quadrant, bus.microcode_result}
          !== {1'b1, expect_done(addr, res, quad, 1'b0, 1'b0)}) begin
         miscompares++;
         $display("[TB] FAIL min_latency: got done=%b err=%b q=%0d res=%h expected 1 0 %0d %h",
                  bus.microcode_done, bus.microcode_error, bus.microcode_quadrant, bus.microcode_result, quad, res);
      end
      idle_inputs();
      step();
   endtask

   // Scenario sequence and summary.
   initial begin
      idle_inputs();
      test_reset();
      test_valid();
      test_invalid();
      test_timeout();
      test_race();
      test_queue();
      test_reset_mid_wait();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
